// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Sweeps all 16 input vectors of a 4-input combinational circuit under test,
// lets each vector settle, samples the circuit response several times, and
// builds a majority-voted truth table. The table is compared against a
// compile-time expected value, and vectors whose readings disagreed are flagged.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//   SAMPLES        consecutive samples per vector, odd (1..15)
//   EXPECTED       reference truth table; bit i is the response to vector i
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_start          request a full sweep (accepted only when idle)
//   i_abort          cancel a sweep in progress (also blocks a start when idle)
//   o_dut_in2/1/4/3  registered stimulus; vector i = {in2, in1, in4, in3}
//   i_dut_out        response of the circuit under test, synchronous to i_clk
//   o_busy           high while settling or sampling
//   o_done           one-cycle completion pulse
//   o_table_out      captured truth table
//   o_match          o_table_out == EXPECTED, valid from the done cycle onward
//   o_unstable_mask  bit i set when the readings for vector i disagreed
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 3,
  parameter logic [15:0] EXPECTED      = 16'h2C26
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_dut_in2,
  output logic        o_dut_in1,
  output logic        o_dut_in4,
  output logic        o_dut_in3,
  input  logic        i_dut_out,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table_out,
  output logic        o_match,
  output logic [15:0] o_unstable_mask
);

  // Phase counter is 8 bits wide so a settle phase of 255 cycles never wraps;
  // the sample phase reuses it (15 samples max).
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
  // Ones-count is 4 bits: at most 15 readings per vector.
  localparam logic [3:0] SAMPLES_W   = 4'(SAMPLES);
  localparam logic [3:0] MAJ_THRESH  = 4'(SAMPLES / 2);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e      r_state;
  logic [3:0]  r_idx;       // current vector index
  logic [3:0]  r_stim;      // registered stimulus, forced to 0 outside a sweep
  logic [7:0]  r_cnt;       // cycles spent in the current phase
  logic [3:0]  r_ones;      // ones seen so far in the current sample phase
  logic        r_busy;
  logic        r_done;
  logic        r_match;
  logic [15:0] r_table;
  logic [15:0] r_unstable;

  logic [3:0]  w_ones_total;
  logic        w_majority;
  logic        w_unstable;
  logic [15:0] w_table_upd;
  logic [15:0] w_unstable_upd;
  logic [3:0]  w_idx_next;

  // Include the reading taken on the current edge, so the final sample of a
  // phase contributes to the vote without an extra cycle.
  assign w_ones_total = r_ones + {3'b000, i_dut_out};
  assign w_majority   = (w_ones_total > MAJ_THRESH);
  assign w_unstable   = (w_ones_total != 4'd0) && (w_ones_total != SAMPLES_W);
  assign w_idx_next   = r_idx + 4'd1;

  // Table contents as they will be after the current vector is committed;
  // also feeds the match compare on the edge that enters StDone.
  always_comb begin
    w_table_upd           = r_table;
    w_unstable_upd        = r_unstable;
    w_table_upd[r_idx]    = w_majority;
    w_unstable_upd[r_idx] = w_unstable;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_idx      <= 4'd0;
      r_stim     <= 4'd0;
      r_cnt      <= 8'd0;
      r_ones     <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_table    <= 16'd0;
      r_unstable <= 16'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Abort held high while idle suppresses a simultaneous start.
          if (i_start && !i_abort) begin
            r_table    <= 16'd0;
            r_unstable <= 16'd0;
            r_match    <= 1'b0;
            r_idx      <= 4'd0;
            r_stim     <= 4'd0;
            r_cnt      <= 8'd0;
            r_ones     <= 4'd0;
            r_busy     <= 1'b1;
            r_state    <= StSettle;
          end
        end

        StSettle: begin
          if (i_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_stim  <= 4'd0;
            r_match <= 1'b0;
            r_cnt   <= 8'd0;
            r_ones  <= 4'd0;
          end else if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= 8'd0;
            r_ones  <= 4'd0;
            r_state <= StSample;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        StSample: begin
          if (i_abort) begin
            // Partial table bits already committed are kept.
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_stim  <= 4'd0;
            r_match <= 1'b0;
            r_cnt   <= 8'd0;
            r_ones  <= 4'd0;
          end else if (r_cnt == SAMPLE_LAST) begin
            r_table    <= w_table_upd;
            r_unstable <= w_unstable_upd;
            r_cnt      <= 8'd0;
            r_ones     <= 4'd0;
            if (r_idx == 4'd15) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_stim  <= 4'd0;
              r_match <= (w_table_upd == EXPECTED);
            end else begin
              // Next vector drives on this same edge so each vector costs
              // exactly SETTLE_CYCLES + SAMPLES cycles.
              r_idx   <= w_idx_next;
              r_stim  <= w_idx_next;
              r_state <= StSettle;
            end
          end else begin
            r_ones <= w_ones_total;
            r_cnt  <= r_cnt + 8'd1;
          end
        end

        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_stim  <= 4'd0;
        end
      endcase
    end
  end

  assign o_dut_in2       = r_stim[3];
  assign o_dut_in1       = r_stim[2];
  assign o_dut_in4       = r_stim[1];
  assign o_dut_in3       = r_stim[0];
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_table_out     = r_table;
  assign o_match         = r_match;
  assign o_unstable_mask = r_unstable;

endmodule
